boot_sync_debounce: RTL and testbench

Boot-clock-domain consumer of the two-flop synchronizer output. Takes the already-synchronized single-bit signal, rejects pulses shorter than a programmable number of boot-clock cycles, and produces a clean debounced level, single-cycle rise/fall strobes and a saturating count of debounced rising events. It sits directly downstream of the synchronizer and feeds boot-sequencing logic. It does no CDC of its own.

---
 rtl/boot_sync_debounce.sv | 140 ++++++++++++++
 tb/tb_boot_sync_debounce.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_sync_debounce.sv
// rtl/boot_sync_debounce.sv - debounce filter, edge strobes and saturating rise counter for a synchronized boot-domain input
module boot_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_in,
    input  logic                 clear,
    output logic                 level_o,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic                 busy_o
);

    localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [QW-1:0] QLAST = QW'(DEBOUNCE_CYCLES - 1);
    localparam logic [QW-1:0] QONE  = QW'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        QUAL_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [QW-1:0]        qcnt_q, qcnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Next-state logic: qualify a new value for DEBOUNCE_CYCLES consecutive samples,
    // abandon the qualification on any sample back at the old value.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_HIGH;
                        qcnt_d  = '0;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = QUAL_HIGH;
                        qcnt_d  = QONE;
                    end
                end
            end
            QUAL_HIGH: begin
                if (!sync_in) begin
                    state_d = STABLE_LOW;
                    qcnt_d  = '0;
                end else if (qcnt_q == QLAST) begin
                    state_d = STABLE_HIGH;
                    qcnt_d  = '0;
                    rise_d  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + QONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync_in) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE_LOW;
                        qcnt_d  = '0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = QUAL_LOW;
                        qcnt_d  = QONE;
                    end
                end
            end
            QUAL_LOW: begin
                if (sync_in) begin
                    state_d = STABLE_HIGH;
                    qcnt_d  = '0;
                end else if (qcnt_q == QLAST) begin
                    state_d = STABLE_LOW;
                    qcnt_d  = '0;
                    fall_d  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + QONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                qcnt_d  = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        level_d = (state_d == STABLE_HIGH) || (state_d == QUAL_LOW);
        busy_d  = (state_d == QUAL_HIGH) || (state_d == QUAL_LOW);
        count_d = count_q;
        if (clear && rise_d) begin
            count_d = CNT_WIDTH'(1);
        end else if (clear) begin
            count_d = '0;
        end else if (rise_d && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // State, qualification counter and registered outputs; reset aborts any qualification.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STABLE_LOW;
            qcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign level_o     = level_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign busy_o      = busy_q;
    assign event_count = count_q;

endmodule

// File: tb/tb_boot_sync_debounce.sv
// tb/tb_boot_sync_debounce.sv - directed self-checking bench for boot_sync_debounce
module tb_boot_sync_debounce;

    logic       clk = 1'b0;
    int         total = 0;
    int         passed = 0;
    int         cyc = 0;

    logic       rst4 = 1'b0, sin4 = 1'b0, clr4 = 1'b0;
    logic       lvl4, rise4, fall4, busy4;
    logic [7:0] cnt4;

    logic       rst1 = 1'b0, sin1 = 1'b0, clr1 = 1'b0;
    logic       lvl1, rise1, fall1, busy1;
    logic [1:0] cnt1;

    always #5 clk = ~clk;

    boot_sync_debounce #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst4), .sync_in(sin4), .clear(clr4),
        .level_o(lvl4), .rise_o(rise4), .fall_o(fall4),
        .event_count(cnt4), .busy_o(busy4)
    );

    boot_sync_debounce #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst1), .sync_in(sin1), .clear(clr1),
        .level_o(lvl1), .rise_o(rise1), .fall_o(fall1),
        .event_count(cnt1), .busy_o(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst4 = 1'b0;
        sin4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({lvl4, rise4, fall4, busy4, cnt4} !== 12'h0)
                $display("FAIL reset_outputs cycle %0d got %b want all zero", i, {lvl4, rise4, fall4, busy4, cnt4});
            else passed++;
        end
        rst4 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if ({lvl4, rise4, busy4} !== 3'b001)
                $display("FAIL reset_release_qual edge %0d got lvl/rise/busy=%b want 001", i, {lvl4, rise4, busy4});
            else passed++;
        end
        tick();
        total++;
        if ({lvl4, rise4, fall4, busy4} !== 4'b1100 || cnt4 !== 8'd1)
            $display("FAIL reset_release_rise got lvl/rise/fall/busy=%b cnt=%0d want 1100 cnt=1", {lvl4, rise4, fall4, busy4}, cnt4);
        else passed++;
        tick();
        total++;
        if ({lvl4, rise4} !== 2'b10 || cnt4 !== 8'd1)
            $display("FAIL reset_rise_one_cycle got lvl/rise=%b cnt=%0d want 10 cnt=1", {lvl4, rise4}, cnt4);
        else passed++;
    endtask

    task automatic test_glitch_reject();
        rst4 = 1'b0;
        sin4 = 1'b0;
        tick();
        tick();
        rst4 = 1'b1;
        for (int p = 0; p < 5; p++) begin
            sin4 = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                total++;
                if ({lvl4, rise4, fall4, busy4} !== 4'b0001)
                    $display("FAIL glitch_high pulse %0d cyc %0d got lvl/rise/fall/busy=%b want 0001", p, i, {lvl4, rise4, fall4, busy4});
                else passed++;
            end
            sin4 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                tick();
                total++;
                if ({lvl4, rise4, fall4, busy4} !== 4'b0000)
                    $display("FAIL glitch_low pulse %0d cyc %0d got lvl/rise/fall/busy=%b want 0000", p, i, {lvl4, rise4, fall4, busy4});
                else passed++;
            end
        end
        total++;
        if (cnt4 !== 8'd0)
            $display("FAIL glitch_count got %0d want 0", cnt4);
        else passed++;
    endtask

    task automatic test_clean_toggle();
        int nr = 0;
        int nf = 0;
        int edge_cyc = 0;
        for (int r = 0; r < 3; r++) begin
            for (int ph = 0; ph < 2; ph++) begin
                sin4 = (ph == 0);
                edge_cyc = cyc;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    if (rise4 || fall4) begin
                        total++;
                        if ((rise4 && fall4) || (rise4 !== sin4) || (cyc - edge_cyc != 4))
                            $display("FAIL toggle_strobe got rise=%b fall=%b lag=%0d want %s lag=4", rise4, fall4, cyc - edge_cyc, sin4 ? "rise" : "fall");
                        else passed++;
                        if (rise4) nr++;
                        if (fall4) nf++;
                    end
                end
            end
        end
        total++;
        if (nr != 3 || nf != 3 || cnt4 !== 8'd3)
            $display("FAIL toggle_totals got rises=%0d falls=%0d cnt=%0d want 3 3 3", nr, nf, cnt4);
        else passed++;
    endtask

    task automatic test_sat_clear();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        rst1 = 1'b0;
        sin1 = 1'b0;
        clr1 = 1'b0;
        tick();
        rst1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sin1 = 1'b1;
            tick();
            total++;
            if (rise1 !== 1'b1 || cnt1 !== 2'(exp_cnt[i]))
                $display("FAIL sat_count event %0d got rise=%b cnt=%0d want rise=1 cnt=%0d", i, rise1, cnt1, exp_cnt[i]);
            else passed++;
            sin1 = 1'b0;
            tick();
        end
        clr1 = 1'b1;
        sin1 = 1'b1;
        tick();
        total++;
        if (rise1 !== 1'b1 || cnt1 !== 2'd1)
            $display("FAIL clear_with_rise got rise=%b cnt=%0d want rise=1 cnt=1", rise1, cnt1);
        else passed++;
        clr1 = 1'b0;
        sin1 = 1'b0;
        tick();
        total++;
        if (cnt1 !== 2'd1 || fall1 !== 1'b1)
            $display("FAIL clear_hold got cnt=%0d fall=%b want cnt=1 fall=1", cnt1, fall1);
        else passed++;
    endtask

    task automatic test_reset_mid_qual();
        sin4 = 1'b1;
        tick();
        tick();
        total++;
        if ({lvl4, busy4} !== 2'b01)
            $display("FAIL midq_before got lvl/busy=%b want 01", {lvl4, busy4});
        else passed++;
        rst4 = 1'b0;
        tick();
        total++;
        if ({lvl4, rise4, busy4} !== 3'b000 || cnt4 !== 8'd0)
            $display("FAIL midq_reset got lvl/rise/busy=%b cnt=%0d want 000 cnt=0", {lvl4, rise4, busy4}, cnt4);
        else passed++;
        rst4 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if ({lvl4, rise4, busy4} !== 3'b001)
                $display("FAIL midq_requal edge %0d got lvl/rise/busy=%b want 001", i, {lvl4, rise4, busy4});
            else passed++;
        end
        tick();
        total++;
        if ({lvl4, rise4, busy4} !== 3'b110 || cnt4 !== 8'd1)
            $display("FAIL midq_rise got lvl/rise/busy=%b cnt=%0d want 110 cnt=1", {lvl4, rise4, busy4}, cnt4);
        else passed++;
    endtask

    task automatic test_n1_random();
        logic m_lvl = 1'b0;
        logic b;
        for (int i = 0; i < 40; i++) begin
            b = 1'($urandom_range(0, 1));
            sin1 = b;
            tick();
            total++;
            if (lvl1 !== b || rise1 !== (b & ~m_lvl) || fall1 !== (~b & m_lvl) || busy1 !== 1'b0)
                $display("FAIL n1_random step %0d got lvl/rise/fall/busy=%b%b%b%b want %b%b%b0", i, lvl1, rise1, fall1, busy1, b, b & ~m_lvl, ~b & m_lvl);
            else passed++;
            m_lvl = b;
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_glitch_reject();
        test_clean_toggle();
        test_sat_clear();
        test_reset_mid_qual();
        test_n1_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
